// File: rtl/cache_pkg.sv
`default_nettype none
// ============================================================================
// Module   : cache_pkg
// Purpose  : Shared types and default sizing for the cache write-back buffer.
//            Holds the address/data typedefs, the write-back entry record and
//            the default depth / almost-full threshold used by cache_wb_fifo.
// Ports    : none (package)
// Revision : 1.0 - initial release
// ============================================================================
package cache_pkg;

    localparam int WB_ADDR_W   = 32;
    localparam int WB_DATA_W   = 32;
    localparam int WB_DEPTH    = 16;
    localparam int WB_AF_LEVEL = 12;

    typedef logic [WB_ADDR_W-1:0] addr_t;
    typedef logic [WB_DATA_W-1:0] data_t;

    typedef struct packed {
        logic  valid;
        addr_t addr;
        data_t data;
    } wb_entry_t;

endpackage : cache_pkg
`default_nettype wire

// File: rtl/wb_match_prio.sv
`default_nettype none
// ============================================================================
// Module   : wb_match_prio
// Purpose  : Combinational associative compare of a key address against every
//            buffer entry, followed by an age-ordered priority select that
//            returns the newest matching entry (age measured from rd_ptr).
// Ports    : key       - address to search for
//            valid     - per-entry valid bits
//            mask      - per-entry exclusion bits (entry ignored when set)
//            addrs     - per-entry stored addresses
//            datas     - per-entry stored data
//            rd_ptr    - slot of the oldest entry
//            hit       - at least one unmasked valid entry matches
//            hit_idx   - slot of the newest match (0 when no hit)
//            hit_data  - data of the newest match (0 when no hit)
// Revision : 1.0 - initial release
// ============================================================================
module wb_match_prio #(
    parameter  int DEPTH  = 16,
    parameter  int ADDR_W = 32,
    parameter  int DATA_W = 32,
    localparam int PW     = $clog2(DEPTH)
) (
    input  logic [ADDR_W-1:0] key,
    input  logic [DEPTH-1:0]  valid,
    input  logic [DEPTH-1:0]  mask,
    input  logic [ADDR_W-1:0] addrs [DEPTH],
    input  logic [DATA_W-1:0] datas [DEPTH],
    input  logic [PW-1:0]     rd_ptr,
    output logic              hit,
    output logic [PW-1:0]     hit_idx,
    output logic [DATA_W-1:0] hit_data
);

    logic [DEPTH-1:0] match;
    logic [PW-1:0]    slot;

    for (genvar i = 0; i < DEPTH; i++) begin : g_cmp
        assign match[i] = valid[i] & ~mask[i] & (addrs[i] == key);
    end

    // Walk slots from oldest to newest; the last match seen is the newest.
    always_comb begin
        hit      = |match;
        hit_idx  = '0;
        hit_data = '0;
        slot     = '0;
        for (int k = 0; k < DEPTH; k++) begin
            slot = rd_ptr + PW'(k);
            if (match[slot]) begin
                hit_idx  = slot;
                hit_data = datas[slot];
            end
        end
    end

endmodule : wb_match_prio
`default_nettype wire

// File: rtl/cache_wb_fifo.sv
`default_nettype none
// ============================================================================
// Module   : cache_wb_fifo
// Purpose  : Single-clock write-back buffer between cache and main memory.
//            Show-ahead FIFO of (address, data) pairs with valid/ready on both
//            sides, associative lookup of pending write-backs, optional
//            coalescing of repeated writes into a pending non-head entry, and
//            a sticky overflow flag for writes attempted while full.
// Ports    : clk, rst             - clock, async active-high reset
//            in_valid/in_ready    - cache-side handshake (in_ready = ~full)
//            in_addr/in_data      - write-back pair
//            out_valid/out_ready  - memory-side handshake
//            out_addr/out_data    - head pair (0 when empty)
//            lookup_addr          - miss address to probe
//            lookup_hit/_data     - newest pending match (data 0 on miss)
//            count/full/empty/almost_full - occupancy status
//            overflow             - sticky, in_valid seen while full
// Revision : 1.0 - initial release
// ============================================================================
module cache_wb_fifo
    import cache_pkg::*;
#(
    parameter  int DEPTH    = WB_DEPTH,
    parameter  int ADDR_W   = $bits(addr_t),
    parameter  int DATA_W   = $bits(data_t),
    parameter  int AF_LEVEL = WB_AF_LEVEL,
    parameter  int COALESCE = 1,
    localparam int PW       = $clog2(DEPTH),
    localparam int CW       = $clog2(DEPTH) + 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [ADDR_W-1:0] in_addr,
    input  logic [DATA_W-1:0] in_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [ADDR_W-1:0] out_addr,
    output logic [DATA_W-1:0] out_data,
    input  logic [ADDR_W-1:0] lookup_addr,
    output logic              lookup_hit,
    output logic [DATA_W-1:0] lookup_data,
    output logic [CW-1:0]     count,
    output logic              full,
    output logic              empty,
    output logic              almost_full,
    output logic              overflow
);

    logic [ADDR_W-1:0] addr_mem [DEPTH];
    logic [DATA_W-1:0] data_mem [DEPTH];
    logic [DEPTH-1:0]  valid;
    logic [PW-1:0]     wr_ptr;
    logic [PW-1:0]     rd_ptr;
    logic [CW-1:0]     cnt;
    logic              ovf;

    logic              push;
    logic              pop;
    logic              coal;
    logic              push_new;
    logic              coal_hit;
    logic [PW-1:0]     coal_idx;
    logic [DATA_W-1:0] coal_data;
    logic [PW-1:0]     look_idx;
    logic [DEPTH-1:0]  head_mask;
    logic              unused_sigs;

    // Status is derived from the occupancy counter, never from the pointers.
    assign full        = (cnt == CW'(DEPTH));
    assign empty       = (cnt == '0);
    assign almost_full = (cnt >= CW'(AF_LEVEL));
    assign in_ready    = ~full;
    assign out_valid   = ~empty;
    assign count       = cnt;
    assign overflow    = ovf;

    assign out_addr    = out_valid ? addr_mem[rd_ptr] : '0;
    assign out_data    = out_valid ? data_mem[rd_ptr] : '0;

    assign push        = in_valid & in_ready;
    assign pop         = out_valid & out_ready;

    // The head may be mid-handshake with memory, so it is never a coalescing
    // target; a write matching only the head is queued as a new entry.
    assign head_mask   = DEPTH'(1) << rd_ptr;
    assign coal        = push & (COALESCE != 0) & coal_hit;
    assign push_new    = push & ~coal;

    wb_match_prio #(
        .DEPTH  (DEPTH),
        .ADDR_W (ADDR_W),
        .DATA_W (DATA_W)
    ) u_lookup (
        .key      (lookup_addr),
        .valid    (valid),
        .mask     ('0),
        .addrs    (addr_mem),
        .datas    (data_mem),
        .rd_ptr   (rd_ptr),
        .hit      (lookup_hit),
        .hit_idx  (look_idx),
        .hit_data (lookup_data)
    );

    wb_match_prio #(
        .DEPTH  (DEPTH),
        .ADDR_W (ADDR_W),
        .DATA_W (DATA_W)
    ) u_coalesce (
        .key      (in_addr),
        .valid    (valid),
        .mask     (head_mask),
        .addrs    (addr_mem),
        .datas    (data_mem),
        .rd_ptr   (rd_ptr),
        .hit      (coal_hit),
        .hit_idx  (coal_idx),
        .hit_data (coal_data)
    );

    assign unused_sigs = ^{coal_data, look_idx};

    // Control state: pointers, occupancy, valid bits and sticky overflow.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            cnt    <= '0;
            valid  <= '0;
            ovf    <= 1'b0;
        end else begin
            if (in_valid & full) begin
                ovf <= 1'b1;
            end
            // A new push never lands on the slot being popped: a pop needs a
            // non-empty buffer and a push needs a non-full one.
            if (push_new) begin
                valid[wr_ptr] <= 1'b1;
                wr_ptr        <= wr_ptr + PW'(1);
            end
            if (pop) begin
                valid[rd_ptr] <= 1'b0;
                rd_ptr        <= rd_ptr + PW'(1);
            end
            cnt <= cnt + CW'(push_new) - CW'(pop);
        end
    end

    // Storage is intentionally not reset; valid bits gate every read.
    always_ff @(posedge clk) begin
        if (push_new) begin
            addr_mem[wr_ptr] <= in_addr;
            data_mem[wr_ptr] <= in_data;
        end else if (coal) begin
            data_mem[coal_idx] <= in_data;
        end
    end

endmodule : cache_wb_fifo
`default_nettype wire

// File: tb/tb_cache_wb_fifo.sv
`default_nettype none
// ============================================================================
// Module   : tb_cache_wb_fifo
// Purpose  : Self-checking bench for cache_wb_fifo. Directed scenarios (reset
//            mid-traffic, ordered drain, wrap, overflow, coalescing, lookup)
//            followed by randomized traffic, all checked by a scoreboard that
//            keeps the pending write-backs as an ordered queue of pairs.
// Ports    : none
// Revision : 1.0 - initial release
// ============================================================================
module tb_cache_wb_fifo;

    localparam int DEPTH = 16;
    localparam int AW    = 32;
    localparam int DW    = 32;
    localparam int AF    = 12;
    localparam int COAL  = 1;
    localparam int CW    = $clog2(DEPTH) + 1;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          in_valid;
    logic          in_ready;
    logic [AW-1:0] in_addr;
    logic [DW-1:0] in_data;
    logic          out_valid;
    logic          out_ready;
    logic [AW-1:0] out_addr;
    logic [DW-1:0] out_data;
    logic [AW-1:0] lookup_addr;
    logic          lookup_hit;
    logic [DW-1:0] lookup_data;
    logic [CW-1:0] count;
    logic          full;
    logic          empty;
    logic          almost_full;
    logic          overflow;

    always #5 clk = ~clk;

    cache_wb_fifo #(
        .DEPTH    (DEPTH),
        .ADDR_W   (AW),
        .DATA_W   (DW),
        .AF_LEVEL (AF),
        .COALESCE (COAL)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .in_addr     (in_addr),
        .in_data     (in_data),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_addr    (out_addr),
        .out_data    (out_data),
        .lookup_addr (lookup_addr),
        .lookup_hit  (lookup_hit),
        .lookup_data (lookup_data),
        .count       (count),
        .full        (full),
        .empty       (empty),
        .almost_full (almost_full),
        .overflow    (overflow)
    );

    typedef struct {
        logic [AW-1:0] a;
        logic [DW-1:0] d;
    } ent_t;

    ent_t q[$];       // pending write-backs, oldest first
    logic ovf_m;
    int   tests = 0;
    int   fails = 0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Scoreboard: at each falling edge compare what the DUT presents against
    // the pending queue, then apply the handshakes that the next rising edge
    // will commit (push before pop, so the old head is excluded from merging).
    always @(negedge clk) begin : scoreboard
        int            n;
        logic          eh;
        logic [DW-1:0] ed;
        logic          merged;
        if (rst) begin
            q.delete();
            ovf_m = 1'b0;
        end else begin
            n = q.size();
            chk("count",       64'(count),       64'(n));
            chk("empty",       64'(empty),       64'(n == 0));
            chk("full",        64'(full),        64'(n == DEPTH));
            chk("almost_full", 64'(almost_full), 64'(n >= AF));
            chk("in_ready",    64'(in_ready),    64'(n < DEPTH));
            chk("out_valid",   64'(out_valid),   64'(n > 0));
            chk("overflow",    64'(overflow),    64'(ovf_m));
            if (n > 0) begin
                chk("out_addr", 64'(out_addr), 64'(q[0].a));
                chk("out_data", 64'(out_data), 64'(q[0].d));
            end else begin
                chk("out_addr_idle", 64'(out_addr), 64'd0);
                chk("out_data_idle", 64'(out_data), 64'd0);
            end
            eh = 1'b0;
            ed = '0;
            for (int i = 0; i < n; i++) begin
                if (q[i].a == lookup_addr) begin
                    eh = 1'b1;
                    ed = q[i].d;
                end
            end
            chk("lookup_hit",  64'(lookup_hit),  64'(eh));
            chk("lookup_data", 64'(lookup_data), 64'(ed));

            if (in_valid && n == DEPTH) ovf_m = 1'b1;
            if (in_valid && n < DEPTH) begin
                merged = 1'b0;
                if (COAL != 0) begin
                    for (int i = n - 1; i >= 1; i--) begin
                        if (!merged && q[i].a == in_addr) begin
                            q[i].d = in_data;
                            merged = 1'b1;
                        end
                    end
                end
                if (!merged) q.push_back('{a: in_addr, d: in_data});
            end
            if (out_ready && n > 0) void'(q.pop_front());
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic [AW-1:0] a, input logic [DW-1:0] d);
        step();
        in_valid = v;
        in_addr  = a;
        in_data  = d;
    endtask

    initial begin
        in_valid    = 1'b0;
        in_addr     = '0;
        in_data     = '0;
        out_ready   = 1'b0;
        lookup_addr = '0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_count",     64'(count),       64'd0);
        chk("rst_empty",     64'(empty),       64'd1);
        chk("rst_full",      64'(full),        64'd0);
        chk("rst_af",        64'(almost_full), 64'd0);
        chk("rst_out_valid", 64'(out_valid),   64'd0);
        chk("rst_hit",       64'(lookup_hit),  64'd0);
        chk("rst_out_addr",  64'(out_addr),    64'd0);
        chk("rst_ovf",       64'(overflow),    64'd0);
        rst = 1'b0;

        // Reset mid-traffic.
        lookup_addr = 32'h500;
        for (int i = 0; i < 5; i++) drive(1'b1, 32'h500 + 32'(i), $urandom);
        drive(1'b0, '0, '0);
        step();
        chk("t1_count_pre", 64'(count),      64'd5);
        chk("t1_hit_pre",   64'(lookup_hit), 64'd1);
        rst = 1'b1;
        #1;
        chk("t1_count",     64'(count),      64'd0);
        chk("t1_empty",     64'(empty),      64'd1);
        chk("t1_out_valid", 64'(out_valid),  64'd0);
        chk("t1_hit",       64'(lookup_hit), 64'd0);
        step();
        rst = 1'b0;

        // Ordered fill to full, then overflow attempts, then ordered drain.
        for (int i = 0; i < 16; i++) drive(1'b1, 32'h100 + 32'(i), 32'hA0 + 32'(i));
        drive(1'b0, '0, '0);
        chk("t2_full",     64'(full),        64'd1);
        chk("t2_in_ready", 64'(in_ready),    64'd0);
        chk("t2_af",       64'(almost_full), 64'd1);
        for (int i = 0; i < 3; i++) drive(1'b1, 32'h200, 32'hDEAD);
        drive(1'b0, '0, '0);
        chk("t4_overflow", 64'(overflow), 64'd1);
        chk("t4_count",    64'(count),    64'd16);
        out_ready = 1'b1;
        repeat (16) step();
        out_ready = 1'b0;
        chk("t2_empty_after", 64'(empty),    64'd1);
        chk("t4_ovf_sticky",  64'(overflow), 64'd1);

        // Steady level of 3 with concurrent push and pop, wrapping pointers.
        for (int i = 0; i < 3; i++) drive(1'b1, 32'h600 + 32'(i), $urandom);
        for (int i = 0; i < 40; i++) begin
            drive(1'b1, 32'h610 + 32'(i), $urandom);
            out_ready = 1'b1;
        end
        drive(1'b0, '0, '0);
        out_ready = 1'b0;
        chk("t3_count", 64'(count), 64'd3);
        out_ready = 1'b1;
        repeat (3) step();
        out_ready = 1'b0;
        chk("t3_empty", 64'(empty), 64'd1);

        // Coalescing into a non-head entry; a head match enqueues normally.
        drive(1'b1, 32'h300, 32'h11);
        drive(1'b1, 32'h304, 32'h22);
        drive(1'b1, 32'h304, 32'h33);
        drive(1'b0, '0, '0);
        chk("t5_count2", 64'(count), 64'd2);
        lookup_addr = 32'h304;
        #1;
        chk("t5_merge_data", 64'(lookup_data), 64'h33);
        drive(1'b1, 32'h300, 32'h44);
        drive(1'b0, '0, '0);
        chk("t5_count3", 64'(count), 64'd3);
        out_ready = 1'b1;
        repeat (3) step();
        out_ready = 1'b0;
        chk("t5_empty", 64'(empty), 64'd1);

        // Lookup priority and pop-cycle visibility.
        drive(1'b1, 32'h400, 32'h55);
        drive(1'b1, 32'h400, 32'h66);
        drive(1'b0, '0, '0);
        lookup_addr = 32'h400;
        #1;
        chk("t6_hit",       64'(lookup_hit),  64'd1);
        chk("t6_data",      64'(lookup_data), 64'h66);
        lookup_addr = 32'h404;
        #1;
        chk("t6_miss_hit",  64'(lookup_hit),  64'd0);
        chk("t6_miss_data", 64'(lookup_data), 64'd0);
        lookup_addr = 32'h400;
        out_ready   = 1'b1;
        step();
        chk("t6_hit_popping",  64'(lookup_hit),  64'd1);
        chk("t6_data_popping", 64'(lookup_data), 64'h66);
        step();
        chk("t6_hit_after", 64'(lookup_hit), 64'd0);
        out_ready = 1'b0;

        // Randomized traffic over a small address set to provoke merges.
        for (int i = 0; i < 3000; i++) begin
            step();
            in_valid    = ($urandom_range(0, 9) < 6);
            in_addr     = 32'h700 + 32'(4 * $urandom_range(0, 7));
            in_data     = $urandom;
            out_ready   = (i < 1500) ? ($urandom_range(0, 9) < 4) : ($urandom_range(0, 9) < 7);
            lookup_addr = 32'h700 + 32'(4 * $urandom_range(0, 7));
        end
        drive(1'b0, '0, '0);
        out_ready = 1'b1;
        repeat (DEPTH + 2) step();
        chk("rand_drained", 64'(empty), 64'd1);
        out_ready = 1'b0;
        step();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule : tb_cache_wb_fifo
`default_nettype wire

// File: doc/cache_wb_fifo.md
Name: cache_wb_fifo

Overview:
Parametrised single-clock write-back buffer between the cache and the main-memory port. It queues evicted (address, data) pairs with valid/ready handshakes on both sides. It provides an associative lookup so a cache miss can be serviced from pending write-backs. It optionally coalesces repeated writes to the same address. It replaces the dual-clock fixed-depth cache-to-main FIFO on single-clock builds.

Parameters:
DEPTH, 16, number of entries; power of two, 2..64.
ADDR_W, 32, address width.
DATA_W, 32, data width.
AF_LEVEL, 12, almost_full asserts when count >= AF_LEVEL.
COALESCE, 1, 1 = merge a write into a matching pending non-head entry; 0 = plain FIFO.

Ports:
clk  in  1  system clock, rising edge.
rst  in  1  asynchronous active-high reset.
in_valid  in  1  cache presents a write-back.
in_ready  out  1  buffer accepts; equals ~full.
in_addr  in  ADDR_W  write-back address.
in_data  in  DATA_W  write-back data.
out_valid  out  1  head entry valid toward memory.
out_ready  in  1  memory accepts head.
out_addr  out  ADDR_W  head address.
out_data  out  DATA_W  head data.
lookup_addr  in  ADDR_W  miss address to probe.
lookup_hit  out  1  a pending entry matches lookup_addr.
lookup_data  out  DATA_W  data of the newest matching entry.
count  out  $clog2(DEPTH)+1  entries held.
full  out  1  count == DEPTH.
empty  out  1  count == 0.
almost_full  out  1  count >= AF_LEVEL.
overflow  out  1  sticky; set when in_valid is high while full.

Behaviour:
- Reset (async, active-high): wr_ptr=0, rd_ptr=0, count=0, overflow=0, valid bits cleared. Outputs: empty=1, full=0, almost_full=0, out_valid=0, lookup_hit=0. out_addr, out_data and lookup_data are 0 while invalid. Storage array is not reset.
- Push: occurs at a rising edge when in_valid & in_ready. Pop: occurs at a rising edge when out_valid & out_ready.
- Pointers are $clog2(DEPTH) bits and wrap naturally. count is tracked separately and is one bit wider.
- Show-ahead read: out_valid = ~empty. out_addr and out_data are driven combinationally from the rd_ptr slot. The handshake is AXI-style: out_valid, out_addr and out_data are held stable until accepted.
- Latency: a push into an empty buffer gives out_valid=1 in the following cycle. There is no same-cycle bypass.
- Simultaneous push and pop:
  - count is unchanged and both pointers advance.
  - This is legal at any non-full level.
  - When full, in_ready=0, so no push happens even if a pop occurs in the same cycle.
- Empty: pop is impossible (out_valid=0). out_ready is ignored.
- Full: in_ready=0. Any in_valid sets overflow, which holds until rst. Data is dropped and the cache must honour in_ready.
- Coalescing (COALESCE=1):
  - A push whose in_addr equals the address of a valid non-head entry overwrites that entry's data.
  - count and wr_ptr are unchanged.
  - If several entries match, the newest is written.
  - A match only on the head entry does not coalesce; it enqueues normally, because the head may be mid-handshake.
  - A coalescing write still requires in_ready=1, so it is blocked when full.
- Lookup:
  - Combinational compare of lookup_addr against all valid entries.
  - lookup_hit is the OR of the per-entry matches. lookup_data comes from the newest match, using priority by age relative to rd_ptr.
  - Lookup reflects state before the current edge: an entry being popped this cycle still hits, and data being pushed this cycle does not.
- Width rules: the count update is count + push_new - pop, where push_new excludes coalesced pushes. almost_full and full are derived from count, not from the pointers.

Decomposition:
- Shared package cache_pkg holds addr_t and data_t typedefs, the wb_entry_t struct {valid, addr, data}, and the DEPTH and AF_LEVEL defaults.
- One sub-module is natural: wb_match_prio (combinational per-entry compare plus age-ordered priority select).
  - It is instanced twice: once on lookup_addr, and once on in_addr for coalescing, with the head masked on the coalescing instance.

Test Plan:
1. Reset mid-traffic: fill 5 entries, assert rst for 1 cycle -> count=0, empty=1, out_valid=0, lookup_hit=0 immediately (async).
2. Ordered drain: push addr 0x100..0x10F with data 0xA0..0xAF while out_ready=0 -> full=1, in_ready=0, almost_full=1 from the 12th push onward. Then set out_ready=1 -> the 16 pairs emerge in order, one per cycle, and empty=1 after the last.
3. Wrap with concurrent push and pop: keep count at 3 with a push and a pop every cycle for 40 cycles -> count stays 3, no loss or duplication, and pointers wrap twice.
4. Overflow: when full, hold in_valid=1 with addr 0x200 -> overflow=1 and stays set, 0x200 never appears on out_addr, count=16.
5. Coalesce (COALESCE=1): push 0x300/0x11, then 0x304/0x22, then 0x304/0x33 -> count=2. The drain order is 0x300/0x11 followed by 0x304/0x33. Push 0x300 again while it is the head -> count=3 and a second 0x300 entry is queued.
6. Lookup: pending 0x400/0x55 and 0x400/0x66 with COALESCE=0 -> lookup_addr=0x400 gives hit=1, data=0x66. lookup_addr=0x404 gives hit=0, data=0. In the cycle the last 0x400 entry pops, hit is still 1; in the next cycle hit=0.
